// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared types, error indices and priority encoder for intr_unit
package intr_pkg;

    localparam int MAX_CH     = 8;
    localparam int CH_IDX_W   = 3;
    localparam int ADDR_MAX_W = 16;

    localparam int ERR_RET_EMPTY  = 0;
    localparam int ERR_STACK_FULL = 1;

    typedef enum logic [0:0] {IDLE = 1'b0, GUARD = 1'b1} state_t;

    // Widest supported entry; the stack packs these fields in this order at ADDR_W.
    typedef struct packed {
        logic [ADDR_MAX_W-1:0] addr;
        logic                  flag;
        logic [CH_IDX_W-1:0]   ch;
    } stack_entry_t;

    typedef struct packed {
        logic                valid;
        logic [CH_IDX_W-1:0] idx;
    } prio_t;

    function automatic prio_t prio_enc(input logic [MAX_CH-1:0] v);
        prio_t r;
        r = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = CH_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/intr_unit_if.sv
// rtl/intr_unit_if.sv - core-side signal bundle between the jacaranda-8 core and intr_unit
interface intr_unit_if #(
    parameter int CH     = 4,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [CH-1:0]     irq;
    logic [CH-1:0]     int_en;
    logic [ADDR_W-1:0] vec_base;
    logic [ADDR_W-1:0] next_pc;
    logic              flag_in;
    logic              ret;
    logic              take;
    logic [ADDR_W-1:0] vector;
    logic [ADDR_W-1:0] ret_addr;
    logic              ret_flag;
    logic [CH-1:0]     active;
    logic [DW-1:0]     depth;
    logic [1:0]        err;

    modport master (
        output irq, int_en, vec_base, next_pc, flag_in, ret,
        input  take, vector, ret_addr, ret_flag, active, depth, err
    );

    modport slave (
        input  irq, int_en, vec_base, next_pc, flag_in, ret,
        output take, vector, ret_addr, ret_flag, active, depth, err
    );

endinterface

// File: rtl/intr_stack.sv
// rtl/intr_stack.sv - small LIFO of interrupt return entries with async reset
module intr_stack #(
    parameter  int DEPTH = 4,
    parameter  int W     = 12,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    // Power-of-two storage lets the count index it directly; slots past DEPTH stay unused.
    logic [W-1:0] mem [2**CW];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < 2**CW; i++) mem[i] <= '0;
        end else if (push && !full) begin
            mem[count] <= din;
            count      <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign top   = empty ? '0 : mem[count - 1'b1];

endmodule

// File: rtl/intr_unit.sv
// rtl/intr_unit.sv - prioritised vectored interrupt unit with return stack
// INTR_NEST_EN selects full nesting/preemption; otherwise a single service level.
module intr_unit
    import intr_pkg::*;
#(
    parameter int CH        = 4,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 4,
    parameter int VEC_SHIFT = 2
) (
    input  logic        clock,
    input  logic        reset,
    intr_unit_if.slave  bus
);

    localparam int DW = $clog2(DEPTH + 1);
`ifdef INTR_NEST_EN
    localparam int EFF_DEPTH = DEPTH;
`else
    localparam int EFF_DEPTH = 1;
`endif
    localparam int SW = $clog2(EFF_DEPTH + 1);
    localparam int EW = ADDR_W + 1 + CH_IDX_W;

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_GUARD = GUARD;

    logic [0:0]          state;
    logic [CH-1:0]       active;
    logic [CH-1:0]       req;
    logic [CH-1:0]       elig;
    logic [1:0]          err;
    prio_t               grant;
    logic                take;
    logic                do_pop;
    logic                full;
    logic                empty;
    logic [SW-1:0]       count;
    logic [EW-1:0]       top_e;
    logic [CH_IDX_W-1:0] top_ch;

    assign req = bus.irq & bus.int_en & ~active;

`ifdef INTR_NEST_EN
    logic blk;

    // A channel may preempt only if it outranks every channel already in service.
    always_comb begin
        elig = '0;
        blk  = 1'b0;
        for (int i = 0; i < CH; i++) begin
            elig[i] = req[i] & ~blk;
            blk     = blk | active[i];
        end
    end
`else
    assign elig = (active == '0) ? req : '0;
`endif

    assign grant  = prio_enc(MAX_CH'(elig));
    assign take   = grant.valid & ~bus.ret & ~full & (state == ST_IDLE) & ~reset;
    assign do_pop = bus.ret & ~empty;

    intr_stack #(
        .DEPTH (EFF_DEPTH),
        .W     (EW)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (take),
        .pop   (do_pop),
        .din   ({bus.next_pc, bus.flag_in, grant.idx}),
        .top   (top_e),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign {bus.ret_addr, bus.ret_flag, top_ch} = top_e;

    assign bus.take   = take;
    assign bus.vector = bus.vec_base + (ADDR_W'(grant.idx) << VEC_SHIFT);
    assign bus.active = active;
    assign bus.depth  = DW'(count);
    assign bus.err    = err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            active <= '0;
            err    <= '0;
        end else begin
            // One guard cycle after every take lets the first vector instruction run.
            state <= take ? ST_GUARD : ST_IDLE;
            if (take)
                active <= active | (CH'(1) << grant.idx);
            else if (do_pop)
                active <= active & ~(CH'(1) << top_ch);
            if (bus.ret && empty)
                err[ERR_RET_EMPTY] <= 1'b1;
`ifdef INTR_NEST_EN
            if (grant.valid && full)
                err[ERR_STACK_FULL] <= 1'b1;
`endif
        end
    end

endmodule
